// File: rtl/fp_accumulate_sequencer.sv
// FP16 accumulate sequencer: streams N operands through an external adder.
// Optional FP_ACC_NAN_ABORT_EN: a NaN partial sum drains the remaining operands.
module fp_accumulate_sequencer #(
    parameter int          COUNT_W  = 8,
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic               in_sub,
    output logic [15:0]        adder_x,
    output logic [15:0]        adder_y,
    output logic               adder_sub,
    input  logic [15:0]        adder_r,
    input  logic               adder_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_result,
    output logic [3:0]         out_flags,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ADD   = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_acc;
    logic [15:0]        r_op;
    logic               r_sub;
    logic [COUNT_W-1:0] r_rem;
    logic               r_nan;
    logic               r_inf;
    logic               r_ovf;

    logic               w_hs;
    logic               w_r_exp_max;
    logic               w_r_nan;
    logic               w_r_inf;
    logic               w_rem_zero;
    logic [15:0]        w_result;

    assign w_r_exp_max = (adder_r[14:10] == 5'h1F);
    assign w_r_nan     = w_r_exp_max && (adder_r[9:0] != 10'd0);
    assign w_r_inf     = w_r_exp_max && (adder_r[9:0] == 10'd0);
    assign w_rem_zero  = (r_rem == '0);
    assign w_hs        = in_valid && in_ready;

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = (count != '0) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = S_ADD;
            end
            S_ADD: begin
`ifdef FP_ACC_NAN_ABORT_EN
                if (w_r_nan && !w_rem_zero)
                    w_next = S_DRAIN;
                else
`endif
                w_next = w_rem_zero ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                if (out_ready)
                    w_next = S_IDLE;
            end
`ifdef FP_ACC_NAN_ABORT_EN
            S_DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && (r_rem == COUNT_W'(1)))
                    w_next = S_DONE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= ACC_INIT;
            r_op    <= 16'h0000;
            r_sub   <= 1'b0;
            r_rem   <= '0;
            r_nan   <= 1'b0;
            r_inf   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_acc <= ACC_INIT;
                r_rem <= count;
                r_nan <= 1'b0;
                r_inf <= 1'b0;
                r_ovf <= 1'b0;
            end
            if (r_state == S_FETCH && w_hs) begin
                r_op  <= in_data;
                r_sub <= in_sub;
                r_rem <= r_rem - COUNT_W'(1);
            end
            if (r_state == S_ADD) begin
                r_acc <= adder_r;
                r_ovf <= r_ovf | adder_ovf;
                r_nan <= r_nan | w_r_nan;
                r_inf <= r_inf | w_r_inf;
            end
`ifdef FP_ACC_NAN_ABORT_EN
            // Drained operands only count down; the adder is never used.
            if (r_state == S_DRAIN && w_hs)
                r_rem <= r_rem - COUNT_W'(1);
`endif
        end
    end

`ifdef FP_ACC_NAN_ABORT_EN
    assign w_result = r_nan ? 16'h7FFF : r_acc;
`else
    assign w_result = r_acc;
`endif

    assign adder_x    = r_acc;
    assign adder_y    = r_op;
    assign adder_sub  = r_sub;
    assign out_valid  = (r_state == S_DONE);
    assign out_result = out_valid ? w_result : 16'h0000;
    assign out_flags  = out_valid ?
                        {r_nan, r_inf, r_ovf, (r_acc[14:0] == 15'd0)} : 4'h0;
    assign busy       = (r_state != S_IDLE);

endmodule
